// File: rtl/addsub_gray_seq.sv
// -----------------------------------------------------------------------------
// addsub_gray_seq
//
// Multi-cycle unsigned adder/subtractor with a carry/borrow input. Operands
// are captured through a valid/ready handshake. The sum is then built CHUNK
// bits per clock over a registered carry chain. The (WIDTH+1)-bit binary
// result and its Gray-code equivalent are held until the consumer accepts
// them.
//
// Handshake rules (both sides): a transfer happens on the rising clk edge where
// valid and ready are both high. The producer holds in_valid and the operands
// until that edge. The consumer sees result/Gray_value stable for as long as
// out_valid is high. in_ready and out_valid are registered. Each depends only on
// the FSM state, so there is no combinational path from in_valid or out_ready.
//
// Optional feature: define ADDSUB_OVERFLOW_EN to add the signed-overflow
// output.
//
// Parameters:
//   WIDTH  operand width in bits (>= 2)
//   CHUNK  bits summed per clock; must divide WIDTH
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   in_valid         operand set presented
//   in_ready         block can accept operands (IDLE only)
//   A, B             unsigned operands
//   carry_borrow_in  carry-in (add) or borrow-in (subtract)
//   mode             0 = add, 1 = subtract
//   out_valid        result available (DONE only)
//   out_ready        consumer accepts result
//   result           binary result; MSB = carry-out (add) / borrow-out (sub)
//   Gray_value       result ^ (result >> 1)
//   overflow         signed overflow (only with ADDSUB_OVERFLOW_EN)
//   state_dbg        current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module addsub_gray_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_borrow_in,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic [WIDTH:0]   Gray_value,
`ifdef ADDSUB_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic [1:0]       state_dbg
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // Keep the counter at least one bit wide even when CHUNK == WIDTH.
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             mode_q;
    logic [WIDTH-1:0] sum_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] b_eff_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] next_sum;
    logic [WIDTH:0]   next_result;
    logic             last_chunk;

    assign state_dbg = state;

    // One chunk of the chain. Subtraction is A + ~B + ~bin. The carry register
    // is preloaded with ~bin on accept, so this datapath is identical for both
    // modes.
    always_comb begin
        a_chunk  = '0;
        b_chunk  = '0;
        next_sum = sum_q;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt == CW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
        b_eff_chunk = mode_q ? ~b_chunk : b_chunk;
        chunk_sum   = {1'b0, a_chunk} + {1'b0, b_eff_chunk} + {{CHUNK{1'b0}}, carry};
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt == CW'(i)) begin
                next_sum[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            end
        end
        // In subtract mode the chain carry-out means "no borrow", so invert it.
        next_result = {mode_q ? ~chunk_sum[CHUNK] : chunk_sum[CHUNK], next_sum};
        last_chunk  = (cnt == CW'(NCHUNK - 1));
    end

`ifdef ADDSUB_OVERFLOW_EN
    // Both operand signs agree and the sum sign differs. This is the same as
    // carry-into-MSB XOR carry-out-of-MSB. It is only sampled on the final
    // edge, when next_sum holds the complete value.
    logic b_eff_msb;
    logic next_overflow;
    always_comb begin
        b_eff_msb     = mode_q ? ~b_q[WIDTH-1] : b_q[WIDTH-1];
        next_overflow = (a_q[WIDTH-1] == b_eff_msb) && (next_sum[WIDTH-1] != a_q[WIDTH-1]);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            carry      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            mode_q     <= 1'b0;
            sum_q      <= '0;
            result     <= '0;
            Gray_value <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
`ifdef ADDSUB_OVERFLOW_EN
            overflow   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= A;
                        b_q      <= B;
                        mode_q   <= mode;
                        carry    <= mode ? ~carry_borrow_in : carry_borrow_in;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_q <= next_sum;
                    carry <= chunk_sum[CHUNK];
                    cnt   <= cnt + CW'(1);
                    if (last_chunk) begin
                        result     <= next_result;
                        Gray_value <= next_result ^ (next_result >> 1);
`ifdef ADDSUB_OVERFLOW_EN
                        overflow   <= next_overflow;
`endif
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_gray_seq.sv
// -----------------------------------------------------------------------------
// tb_addsub_gray_seq
//
// Directed bench for addsub_gray_seq. Two instances share all inputs:
//   dut  WIDTH=8, CHUNK=2 (latency 4)
//   dut8 WIDTH=8, CHUNK=8 (latency 1)
// Both accept on the same edge. dut8 waits in DONE until the shared out_ready
// releases both. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_addsub_gray_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid, out_ready, mode, cbi;
  logic [7:0] a, b;

  logic       in_ready, out_valid;
  logic [8:0] result, gray;
  logic [1:0] state_dbg;
  logic       in_ready8, out_valid8;
  logic [8:0] result8, gray8;
  logic [1:0] state_dbg8;
`ifdef ADDSUB_OVERFLOW_EN
  logic       ovf, ovf8;
`endif

  addsub_gray_seq #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .carry_borrow_in(cbi), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .Gray_value(gray),
`ifdef ADDSUB_OVERFLOW_EN
    .overflow(ovf),
`endif
    .state_dbg(state_dbg)
  );

  addsub_gray_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .A(a), .B(b), .carry_borrow_in(cbi), .mode(mode),
    .out_valid(out_valid8), .out_ready(out_ready),
    .result(result8), .Gray_value(gray8),
`ifdef ADDSUB_OVERFLOW_EN
    .overflow(ovf8),
`endif
    .state_dbg(state_dbg8)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One full operation. hold > 0 keeps out_ready low for that many cycles
  // while in_valid/A wiggle.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tc, input logic tm, input logic [8:0] egray,
                        input logic eovf, input int hold);
    int         wait_n;
    int         lat;
    int         lat8;
    logic [8:0] exp_r;
    @(negedge clk);
    wait_n = 0;
    while (!(in_ready && in_ready8) && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check({tag, " in_ready"}, {31'd0, in_ready & in_ready8}, 32'd1);
    a = ta; b = tb_v; cbi = tc; mode = tm; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Operands change after accept; the latched copy must be used.
    in_valid = 1'b0; a = ~ta; b = ~tb_v; cbi = ~tc; mode = ~tm;
    check({tag, " busy"}, {31'd0, in_ready}, 32'd0);
    lat = 0; lat8 = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid8 && lat8 == 0) lat8 = lat;
    end
    check({tag, " latency"}, lat, 32'd4);
    check({tag, " latency8"}, lat8, 32'd1);
    exp_r = exp_q.pop_front();
    check({tag, " result"}, {23'd0, result}, {23'd0, exp_r});
    check({tag, " gray"}, {23'd0, gray}, {23'd0, egray});
    check({tag, " result8"}, {23'd0, result8}, {23'd0, exp_r});
    check({tag, " gray8"}, {23'd0, gray8}, {23'd0, egray});
`ifdef ADDSUB_OVERFLOW_EN
    check({tag, " ovf"}, {31'd0, ovf}, {31'd0, eovf});
    check({tag, " ovf8"}, {31'd0, ovf8}, {31'd0, eovf});
`else
    if (eovf === 1'bx) $display("note: overflow expectation undefined for %s", tag);
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      a = 8'($urandom_range(0, 255));
      @(negedge clk);
      check({tag, " hold in_ready"}, {31'd0, in_ready | in_ready8}, 32'd0);
      check({tag, " hold valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " hold result"}, {23'd0, result}, {23'd0, exp_r});
      check({tag, " hold gray"}, {23'd0, gray}, {23'd0, egray});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " released"}, {30'd0, out_valid, in_ready}, 32'd1);
    check({tag, " state idle"}, {30'd0, state_dbg}, 32'd0);
  endtask

  // Accept an operation, let two chunks complete, then pulse reset.
  task automatic reset_mid(input logic [7:0] ta, input logic [7:0] tb_v);
    @(negedge clk);
    a = ta; b = tb_v; cbi = 1'b0; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid state run", {30'd0, state_dbg}, 32'd1);
    check("mid state8 done", {30'd0, state_dbg8}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("rst in_ready", {30'd0, in_ready, in_ready8}, 32'd3);
    check("rst out_valid", {30'd0, out_valid, out_valid8}, 32'd0);
    check("rst result", {14'd0, result, result8}, 32'd0);
    check("rst gray", {14'd0, gray, gray8}, 32'd0);
    check("rst state", {28'd0, state_dbg, state_dbg8}, 32'd0);
`ifdef ADDSUB_OVERFLOW_EN
    check("rst ovf", {30'd0, ovf, ovf8}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mode = 1'b0; cbi = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result", {23'd0, result}, 32'd0);
    check("reset gray", {23'd0, gray}, 32'd0);
    check("reset state", {30'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;

    exp_q.push_back(9'd43);  run_op("add43",   8'd32,  8'd10,  1'b1, 1'b0, 9'd62,  1'b0, 0);
    exp_q.push_back(9'd507); run_op("sub507",  8'd56,  8'd60,  1'b1, 1'b1, 9'd262, 1'b0, 0);
    exp_q.push_back(9'd510); run_op("add510",  8'd255, 8'd255, 1'b0, 1'b0, 9'd257, 1'b0, 0);
    exp_q.push_back(9'd259); run_op("sub259",  8'd2,   8'd255, 1'b0, 1'b1, 9'd386, 1'b0, 0);
    exp_q.push_back(9'd128); run_op("ovf_add", 8'd127, 8'd1,   1'b0, 1'b0, 9'd192, 1'b1, 0);
    exp_q.push_back(9'd127); run_op("ovf_sub", 8'd128, 8'd1,   1'b0, 1'b1, 9'd64,  1'b1, 0);
    exp_q.push_back(9'd0);   run_op("sub0",    8'd0,   8'd0,   1'b0, 1'b1, 9'd0,   1'b0, 0);
    exp_q.push_back(9'd511); run_op("sub_bin", 8'd0,   8'd0,   1'b1, 1'b1, 9'd256, 1'b0, 0);
    exp_q.push_back(9'd127); run_op("hold",    8'd100, 8'd27,  1'b0, 1'b0, 9'd64,  1'b0, 10);

    reset_mid(8'd90, 8'd9);
    exp_q.push_back(9'd99);  run_op("post_rst", 8'd200, 8'd100, 1'b1, 1'b1, 9'd82, 1'b1, 0);

    check("queue empty", exp_q.size(), 32'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
